// File: rtl/adventure_pkg.sv
// Shared types and defaults for the dungeon move controller.
package adventure_pkg;

  typedef enum logic [2:0] {RESTART, IDLE, ISSUE, SETTLE, OVER} ctrl_state_t;
  typedef enum logic [1:0] {DIR_N, DIR_S, DIR_E, DIR_W} dir_t;

  localparam int CNT_W_DEF       = 8;
  localparam int COOLDOWN_DEF    = 2;
  localparam int RESTART_CYC_DEF = 2;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// One-bit rising-edge detector on a debounced button level.
module rise_detect (
  input  logic clock,
  input  logic R_n,
  input  logic lvl,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clock or negedge R_n) begin
    if (!R_n) prev_q <= 1'b0;
    else      prev_q <= lvl;
  end

  assign rise = lvl & ~prev_q;

endmodule

// File: rtl/adventure_move_ctrl.sv
// Turns button presses into single-cycle move pulses for the dungeon room machine.
//   state   | meaning
//   RESTART | holding room machine in reset, clearing game progress
//   IDLE    | waiting for a direction press or an end-of-game room
//   ISSUE   | one-cycle move pulse on the latched direction
//   SETTLE  | cooldown while the room machine settles after a move
//   OVER    | game ended (won or died), direction input locked out
module adventure_move_ctrl
  import adventure_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int COOLDOWN    = COOLDOWN_DEF,
  parameter int RESTART_CYC = RESTART_CYC_DEF
) (
  input  logic             clock,
  input  logic             R_n,
  input  logic             btn_n,
  input  logic             btn_s,
  input  logic             btn_e,
  input  logic             btn_w,
  input  logic             btn_new,
  input  logic             room_sw,
  input  logic             room_win,
  input  logic             room_d,
  output logic             mv_n,
  output logic             mv_s,
  output logic             mv_e,
  output logic             mv_w,
  output logic             mv_v,
  output logic             room_R,
  output logic [CNT_W-1:0] move_cnt,
  output logic             busy,
  output logic             game_over,
  output logic             won
);

  localparam int SW = cnt_bits(COOLDOWN);
  localparam int RW = cnt_bits(RESTART_CYC);

  logic ev_n, ev_s, ev_e, ev_w, ev_new;

  rise_detect u_rd_n   (.clock(clock), .R_n(R_n), .lvl(btn_n),   .rise(ev_n));
  rise_detect u_rd_s   (.clock(clock), .R_n(R_n), .lvl(btn_s),   .rise(ev_s));
  rise_detect u_rd_e   (.clock(clock), .R_n(R_n), .lvl(btn_e),   .rise(ev_e));
  rise_detect u_rd_w   (.clock(clock), .R_n(R_n), .lvl(btn_w),   .rise(ev_w));
  rise_detect u_rd_new (.clock(clock), .R_n(R_n), .lvl(btn_new), .rise(ev_new));

  ctrl_state_t      state_q, state_d;
  dir_t             dir_q, dir_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic [SW-1:0]    scnt_q, scnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sword_q, sword_d;
  logic             over_q, over_d;
  logic             won_q, won_d;
  logic             room_r_q, room_r_d;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    rcnt_d   = rcnt_q;
    scnt_d   = scnt_q;
    cnt_d    = cnt_q;
    sword_d  = sword_q;
    over_d   = over_q;
    won_d    = won_q;

    if (state_q != RESTART && room_sw) sword_d = 1'b1;

    case (state_q)
      RESTART: begin
        sword_d = 1'b0;
        cnt_d   = '0;
        over_d  = 1'b0;
        won_d   = 1'b0;
        if (rcnt_q == RW'(RESTART_CYC - 1)) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      IDLE: begin
        if (room_win || room_d) begin
          state_d = OVER;
          over_d  = 1'b1;
          won_d   = room_win;
        end else if (ev_n || ev_s || ev_e || ev_w) begin
          state_d = ISSUE;
          if (ev_n)      dir_d = DIR_N;
          else if (ev_s) dir_d = DIR_S;
          else if (ev_e) dir_d = DIR_E;
          else           dir_d = DIR_W;
        end
      end
      ISSUE: begin
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        state_d = SETTLE;
        scnt_d  = SW'(COOLDOWN - 1);
      end
      SETTLE: begin
        if (scnt_q == '0) begin
          if (room_win || room_d) begin
            state_d = OVER;
            over_d  = 1'b1;
            won_d   = room_win;
          end else begin
            state_d = IDLE;
          end
        end else begin
          scnt_d = scnt_q - SW'(1);
        end
      end
      OVER: ;
      default: state_d = RESTART;
    endcase

    // New-game press overrides every other transition outside RESTART.
    if (state_q != RESTART && ev_new) begin
      state_d = RESTART;
      rcnt_d  = '0;
    end

    room_r_d = (state_d == RESTART);
  end

  always_ff @(posedge clock or negedge R_n) begin
    if (!R_n) begin
      state_q  <= RESTART;
      dir_q    <= DIR_N;
      rcnt_q   <= '0;
      scnt_q   <= '0;
      cnt_q    <= '0;
      sword_q  <= 1'b0;
      over_q   <= 1'b0;
      won_q    <= 1'b0;
      room_r_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      rcnt_q   <= rcnt_d;
      scnt_q   <= scnt_d;
      cnt_q    <= cnt_d;
      sword_q  <= sword_d;
      over_q   <= over_d;
      won_q    <= won_d;
      room_r_q <= room_r_d;
    end
  end

  assign mv_n      = (state_q == ISSUE) && (dir_q == DIR_N);
  assign mv_s      = (state_q == ISSUE) && (dir_q == DIR_S);
  assign mv_e      = (state_q == ISSUE) && (dir_q == DIR_E);
  assign mv_w      = (state_q == ISSUE) && (dir_q == DIR_W);
  assign mv_v      = sword_q;
  assign room_R    = room_r_q;
  assign move_cnt  = cnt_q;
  assign busy      = (state_q != IDLE);
  assign game_over = over_q;
  assign won       = won_q;

endmodule

// File: tb/tb_adventure_move_ctrl.sv
// Randomized and directed bench for adventure_move_ctrl with a dungeon room model in the loop.
module tb_adventure_move_ctrl;

  localparam int CNT_W       = 3;
  localparam int COOLDOWN    = 2;
  localparam int RESTART_CYC = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  localparam logic [4:0] B_N = 5'b00001, B_S = 5'b00010, B_E = 5'b00100,
                         B_W = 5'b01000, B_NEW = 5'b10000;

  logic clock = 1'b0;
  logic R_n   = 1'b0;
  logic [4:0] btns = '0;

  logic btn_n, btn_s, btn_e, btn_w, btn_new;
  logic room_sw, room_win, room_d;
  logic mv_n, mv_s, mv_e, mv_w, mv_v, room_R, busy, game_over, won;
  logic [CNT_W-1:0] move_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference controller: restart cycles left, pending pulse, settle cycles left, ended.
  int   m_rst, m_settle, m_pdir, m_cnt;
  bit   m_pulse, m_end, m_won, m_sword;
  logic [4:0] m_prev;

  // Dungeon: 3x2 grid, start (0,0), stash (0,1), (2,1) is vault with sword else graveyard.
  int rx, ry;
  bit r_dead, r_win;

  assign {btn_new, btn_w, btn_e, btn_s, btn_n} = btns;
  assign room_sw  = (rx == 0) && (ry == 1);
  assign room_win = r_win;
  assign room_d   = r_dead;

  always #5 clock = ~clock;

  adventure_move_ctrl #(
    .CNT_W(CNT_W), .COOLDOWN(COOLDOWN), .RESTART_CYC(RESTART_CYC)
  ) dut (
    .clock(clock), .R_n(R_n),
    .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e), .btn_w(btn_w), .btn_new(btn_new),
    .room_sw(room_sw), .room_win(room_win), .room_d(room_d),
    .mv_n(mv_n), .mv_s(mv_s), .mv_e(mv_e), .mv_w(mv_w), .mv_v(mv_v),
    .room_R(room_R), .move_cnt(move_cnt), .busy(busy),
    .game_over(game_over), .won(won)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_rst = RESTART_CYC; m_settle = 0; m_pdir = 0; m_cnt = 0;
    m_pulse = 0; m_end = 0; m_won = 0; m_sword = 0; m_prev = '0;
    rx = 0; ry = 0; r_dead = 0; r_win = 0;
  endtask

  task automatic model_step();
    logic [4:0] ev;
    bit cur_pulse, cur_sword, cur_rr, w_in, d_in, s_in;
    int cur_dir;
    ev = btns & ~m_prev;
    cur_pulse = m_pulse; cur_dir = m_pdir; cur_sword = m_sword; cur_rr = (m_rst > 0);
    w_in = room_win; d_in = room_d; s_in = room_sw;

    if (m_rst > 0) begin
      m_rst--; m_sword = 0; m_cnt = 0; m_end = 0; m_won = 0;
    end else begin
      if (s_in) m_sword = 1;
      if (cur_pulse) m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
      if (ev[4]) begin
        m_rst = RESTART_CYC; m_pulse = 0; m_settle = 0;
      end else if (cur_pulse) begin
        m_pulse = 0; m_settle = COOLDOWN;
      end else if (m_settle > 0) begin
        if (m_settle == 1 && (w_in || d_in)) begin m_end = 1; m_won = w_in; end
        m_settle--;
      end else if (!m_end) begin
        if (w_in || d_in) begin
          m_end = 1; m_won = w_in;
        end else if (|ev[3:0]) begin
          m_pulse = 1;
          m_pdir  = ev[0] ? 0 : ev[1] ? 1 : ev[2] ? 2 : 3;
        end
      end
    end
    m_prev = btns;

    if (cur_rr) begin
      rx = 0; ry = 0; r_dead = 0; r_win = 0;
    end else if (cur_pulse && !r_dead && !r_win) begin
      rx = rx + (cur_dir == 2 ? 1 : 0) - (cur_dir == 3 ? 1 : 0);
      ry = ry + (cur_dir == 1 ? 1 : 0) - (cur_dir == 0 ? 1 : 0);
      if (rx < 0) rx = 0;
      if (rx > 2) rx = 2;
      if (ry < 0) ry = 0;
      if (ry > 1) ry = 1;
      if (rx == 2 && ry == 1) begin
        if (cur_sword) r_win = 1;
        else           r_dead = 1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] mv_exp;
    mv_exp = m_pulse ? 4'(1 << m_pdir) : 4'b0000;
    check_val("mv",        {28'd0, mv_w, mv_e, mv_s, mv_n}, {28'd0, mv_exp});
    check_val("room_R",    {31'd0, room_R},    {31'd0, (m_rst > 0)});
    check_val("busy",      {31'd0, busy},
              {31'd0, !(m_rst == 0 && !m_pulse && m_settle == 0 && !m_end)});
    check_val("move_cnt",  32'(move_cnt),      32'(m_cnt));
    check_val("mv_v",      {31'd0, mv_v},      {31'd0, m_sword});
    check_val("game_over", {31'd0, game_over}, {31'd0, m_end});
    check_val("won",       {31'd0, won},       {31'd0, m_won});
  endtask

  // Called at a negedge: drive buttons, advance one cycle, check at the next negedge.
  task automatic tick(input logic [4:0] b);
    btns = b;
    @(posedge clock);
    #1;
    model_step();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic press(input logic [4:0] b);
    tick(b);
    repeat (4) tick('0);
  endtask

  task automatic new_game();
    tick(B_NEW);
    repeat (3) tick('0);
  endtask

  initial begin
    logic [4:0] rb;

    model_reset();
    repeat (3) begin
      @(negedge clock);
      check_outputs();
    end
    R_n = 1'b1;
    repeat (3) tick('0);
    check_val("post_reset_room_R", {31'd0, room_R}, 32'd0);
    check_val("post_reset_busy",   {31'd0, busy},   32'd0);

    // Single held press; a south press during the settle window is dropped.
    tick(B_E);
    tick(B_E);
    repeat (8) tick(B_E | B_S);
    repeat (4) tick('0);
    check_val("single_cnt", 32'(move_cnt), 32'd1);

    new_game();
    press(B_N | B_W);
    check_val("arb_cnt", 32'(move_cnt), 32'd1);

    new_game();
    press(B_E); press(B_S); press(B_W);
    check_val("sword_held", {31'd0, mv_v}, 32'd1);
    press(B_E); press(B_E);
    check_val("win_over", {31'd0, game_over}, 32'd1);
    check_val("win_won",  {31'd0, won},       32'd1);
    press(B_N); press(B_W);
    check_val("win_locked_cnt", 32'(move_cnt), 32'd5);

    new_game();
    press(B_E); press(B_S); press(B_E);
    check_val("death_over", {31'd0, game_over}, 32'd1);
    check_val("death_won",  {31'd0, won},       32'd0);
    tick(B_NEW);
    check_val("restart_R1", {31'd0, room_R}, 32'd1);
    tick('0);
    check_val("restart_R2", {31'd0, room_R}, 32'd1);
    tick('0);
    check_val("restart_cnt",  32'(move_cnt),     32'd0);
    check_val("restart_sw",   {31'd0, mv_v},      32'd0);
    check_val("restart_over", {31'd0, game_over}, 32'd0);
    check_val("restart_idle", {31'd0, busy},      32'd0);

    new_game();
    for (int i = 0; i < 9; i++) begin
      press((i % 2 == 0) ? B_E : B_W);
      if (i == 6) check_val("sat_cnt7", 32'(move_cnt), 32'd7);
    end
    check_val("sat_hold", 32'(move_cnt), 32'd7);

    // Asynchronous reset in the middle of a move pulse.
    new_game();
    tick(B_E);
    check_val("mid_pulse", {28'd0, mv_w, mv_e, mv_s, mv_n}, 32'd4);
    btns = '0;
    R_n  = 1'b0;
    #1;
    check_val("async_mv",     {28'd0, mv_w, mv_e, mv_s, mv_n}, 32'd0);
    check_val("async_room_R", {31'd0, room_R}, 32'd1);
    model_reset();
    repeat (2) begin
      @(negedge clock);
      check_outputs();
    end
    R_n = 1'b1;
    repeat (3) tick('0);

    rb = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 3) == 0) rb[k] = ~rb[k];
      rb[4] = rb[4] ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 79) == 0);
      tick(rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adventure_move_ctrl.md
Name: adventure_move_ctrl

Overview:
- Sequences the dungeon room state machine from player button inputs.
- Edge-detects the debounced direction buttons and arbitrates simultaneous presses.
- Issues exactly one single-cycle move pulse per accepted press, then waits a settle window.
- Tracks whether the sword has been found, counts moves, locks out input after a win or death, and drives the room machine's active-high reset for new-game restarts.

Parameters:
- CNT_W, 8: width of the move counter.
- COOLDOWN, 2: cycles spent in SETTLE after each issued move (must be at least 1).
- RESTART_CYC, 2: cycles room_R is held high per restart (must be at least 1).

Ports:
- clock, input, 1: system clock, rising edge.
- R_n, input, 1: asynchronous active-low reset.
- btn_n, btn_s, btn_e, btn_w, input, 1 each: debounced direction button levels.
- btn_new, input, 1: debounced new-game button level.
- room_sw, input, 1: room machine is in the stash.
- room_win, input, 1: room machine is in the vault.
- room_d, input, 1: room machine is in the graveyard.
- mv_n, mv_s, mv_e, mv_w, output, 1 each: single-cycle move pulses to the room machine.
- mv_v, output, 1: sword-held level to the room machine.
- room_R, output, 1: active-high reset to the room machine; a flop output.
- move_cnt, output, CNT_W: number of issued moves, saturating.
- busy, output, 1: high whenever the state is not IDLE.
- game_over, output, 1: game has ended.
- won, output, 1: game ended in the vault.

Behaviour:
- Single clock; reset is asynchronous, active-low, on R_n.
- Reset values:
  - state = RESTART, restart counter = 0.
  - room_R = 1, mv_* = 0, mv_v = 0, move_cnt = 0.
  - game_over = 0, won = 0, busy = 1.
  - All edge-detect history registers = 0.
- Press event: a rising edge of a button level, i.e. current = 1 and registered previous = 0. Holding a button produces one event only.
- Simultaneous direction events in one cycle: priority n > s > e > w. Losing events are discarded, not queued.
- Direction events arriving in any state other than IDLE are discarded.
- States:
  - RESTART: held for RESTART_CYC cycles. Clears sword, move_cnt, game_over and won, then goes to IDLE. btn_new is ignored here.
  - IDLE:
    - If room_win or room_d is high, go to OVER (this beats any event).
    - Otherwise, on an accepted direction event, latch the direction and go to ISSUE.
  - ISSUE: lasts exactly one cycle.
    - mv_<dir> = 1 and all other mv_* = 0.
    - move_cnt increments, holding at all-ones once saturated.
    - Next state is SETTLE, with the settle counter loaded to COOLDOWN-1.
  - SETTLE: counts down. When the count reaches 0:
    - go to OVER if room_win or room_d is high;
    - otherwise go to IDLE.
  - OVER:
    - game_over = 1.
    - won is registered from room_win on entry and held.
    - Direction events are ignored.
- btn_new event in any state except RESTART: go to RESTART next cycle. This overrides everything, including a pending ISSUE.
- mv_* are pure decodes of (state == ISSUE) and the latched direction. At most one is high at a time, never for two consecutive cycles.
- Press latency: edge present at cycle k in IDLE → ISSUE (mv pulse) in cycle k+1. The room machine updates at the end of k+1.
- Sword tracking:
  - The sword flop sets whenever room_sw = 1 in any state except RESTART.
  - Once set, it clears only in RESTART.
  - mv_v = the sword flop.
- room_R flop loads (next_state == RESTART) every cycle. It is therefore high for exactly RESTART_CYC cycles after R_n deassertion or a btn_new event, and 0 from the first IDLE cycle.
- Reset mid-operation: R_n low at any time aborts any pulse immediately (mv_* = 0 asynchronously) and re-enters RESTART.

Decomposition:
- Package adventure_pkg:
  - ctrl_state_t enum: RESTART, IDLE, ISSUE, SETTLE, OVER.
  - dir_t enum: DIR_N, DIR_S, DIR_E, DIR_W.
  - Default constants for COOLDOWN and RESTART_CYC.
- Sub-module rise_detect: 1-bit rising-edge detector, clock plus asynchronous active-low R_n, history reset to 0. Instantiated five times (four directions plus btn_new).

Test Plan:
- Reset: R_n low 3 cycles → room_R = 1, mv_* = 0, move_cnt = 0, busy = 1. After release, room_R stays 1 for 2 cycles then 0, and busy = 0.
- Single press: btn_e rises and is held 10 cycles → mv_e = 1 for exactly one cycle, one cycle after the edge; move_cnt = 1; no further pulses. A btn_s press during SETTLE produces no pulse.
- Arbitration: btn_n and btn_w rise in the same cycle → only mv_n pulses, move_cnt = 1.
- Sword win, with a room machine model in the loop: presses e, s, w → room_sw = 1 and mv_v latches 1. Then e, e → room_win, giving game_over = 1 and won = 1. Later presses produce no mv pulses.
- Death and restart: presses e, s, e without the sword → room_d, giving game_over = 1 and won = 0. A btn_new rise then gives room_R = 1 for 2 cycles, move_cnt = 0, mv_v = 0, game_over = 0, then IDLE.
- Saturation: with CNT_W = 3, make 9 accepted presses → move_cnt = 7 after the 7th and stays 7.
